ctrl_pipe: RTL and testbench
============================

// Module: ctrl_pipe
// PURPOSE
//  Pipelined control unit: decodes the 5-bit opcode in ID and carries the control bundle through EX/MEM/WB.
//  Adds what the flat decoder lacks: load-use stall, branch flush, memory-stall freeze, halt drain FSM, stall watchdog.
//  Sits between fetch/decode and the datapath stage registers; datapath muxes read the per-stage outputs.
// PARAMETERS
//  REG_W      3        register index width
//  HALT_OP    5'b00000 opcode treated as HALT
//  STALL_MAX  255      max consecutive mem_stall cycles before err; counter width = clog2(STALL_MAX+1)
// PORTS
//  clk         in   1      clock, rising edge
//  rst         in   1      synchronous reset, active-low (rst==0 on a clk edge resets)
//  id_valid    in   1      ID holds a real instruction
//  id_opcode   in   5      ID opcode
//  id_rs       in   REG_W  ID source reg 1
//  id_rt       in   REG_W  ID source reg 2
//  id_rs_used  in   1      ID instruction reads rs
//  id_rt_used  in   1      ID instruction reads rt
//  id_dst      in   REG_W  ID destination reg (already muxed)
//  flush       in   1      taken branch/jump resolved in EX; squash ID
//  mem_stall   in   1      data memory busy; freeze whole pipe
//  id_stall    out  1      hold PC/IF-ID (load-use, mem_stall or halt drain)
//  ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc2, ex_branch, ex_jump  out 1 each  EX control
//  ex_dst      out  REG_W  EX destination
//  mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg  out 1 each  MEM control
//  mem_dst     out  REG_W  MEM destination
//  wb_valid, wb_regwrite  out 1 each  WB control
//  wb_dst      out  REG_W  WB destination
//  halted      out  1      sticky; HALT has retired from WB
//  err         out  1      sticky; illegal opcode or stall watchdog expired
// BEHAVIOUR
//  Reset: all outputs 0, all stage valids 0, FSM=RUN, watchdog=0.
//  Decode (combinational on id_opcode): memread=10001; memwrite=10000,10011; memtoreg=10001;
//   branch=011xx; jump=001x1 (disp 001x0 sets jump too); alusrc2=0 for x11xx and 110x1/1101x, else 1;
//   regwrite per ISA table (ALU, SET 111xx, LBI 11000, SLBI 10010, BTR 11001, load, STU, JAL/JALR 0011x).
//   Undefined opcode with id_valid: enters EX as bubble, err<=1.
//  Advance rule, priority high->low each cycle:
//   1 mem_stall=1: all stages hold; flush ignored (source holds it); watchdog++; id_stall=1.
//   2 flush=1: EX<=bubble (valid=0, all ctrl 0); MEM<=EX; WB<=MEM.
//   3 load-use: ex_valid&ex_memread&((id_rs_used&id_rs==ex_dst)|(id_rt_used&id_rt==ex_dst)) -> EX<=bubble, id_stall=1.
//   4 else EX<=decoded ID (valid=id_valid); MEM<=EX; WB<=MEM.
//  Watchdog clears on any cycle with mem_stall=0; reaching STALL_MAX sets err (counter saturates).
//  Bubble: valid=0 and every control bit 0; dst fields don't-care but driven 0.
//  Latency: ID->EX 1 cycle, EX->MEM 1, MEM->WB 1 when not frozen.
//  FSM RUN: HALT accepted into EX -> DRAIN. DRAIN: id_stall=1, EX fed bubbles; halt tag reaching WB -> HALTED.
//   HALTED: halted=1, all stages bubbles, id_stall=1 until reset. Flush of a HALT in ID stays RUN.
//  Reset mid-operation (any state, mid-stall) returns to reset values next edge; halted and err cleared.
// TESTING
//  1 Reset low 2 cycles mid-stream -> all valids 0, halted=0, err=0, FSM RUN.
//  2 LD r1 (10001, dst=1) then ADD using rs=1 -> id_stall=1 one cycle, EX bubble, then ADD in EX with ex_regwrite=1.
//  3 BEQZ in EX asserts flush with ST in ID -> next cycle ex_valid=0, ex_memwrite=0; branch moves to MEM.
//  4 mem_stall high 3 cycles with flush high -> stage outputs unchanged 3 cycles; flush acted on cycle 4 only.
//  5 HALT followed by ADDI -> ADDI never enters EX; halted=1 exactly 3 cycles after HALT enters EX (no stalls).
//  6 STALL_MAX=4, mem_stall held 5 cycles -> err=1 after 4th stalled cycle, stays 1 after mem_stall drops.

Source files
------------

// File: rtl/ctrl_pipe.sv
// -----------------------------------------------------------------------------
// ctrl_pipe
// Pipelined control unit. Decodes the 5-bit opcode sitting in ID and carries
// the resulting control bundle through the EX, MEM and WB stage registers.
// On top of a flat decoder it provides:
//   - load-use interlock (bubble into EX, hold ID)
//   - branch/jump flush (squash the instruction in ID)
//   - whole-pipe freeze while data memory is busy
//   - halt drain FSM (RUN -> DRAIN -> HALTED)
//   - watchdog on consecutive memory-stall cycles
//
// Parameters
//   REG_W      register index width
//   HALT_OP    opcode treated as HALT
//   STALL_MAX  consecutive mem_stall cycles that trip err
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-low reset
//   id_valid, id_opcode      ID instruction present / its opcode
//   id_rs, id_rt             ID source registers
//   id_rs_used, id_rt_used   ID instruction actually reads rs / rt
//   id_dst                   ID destination register (already muxed)
//   flush                    taken branch/jump resolved in EX, squash ID
//   mem_stall                data memory busy, freeze the pipe
//   id_stall                 hold PC and IF/ID register
//   ex_*                     EX stage control and destination
//   mem_*                    MEM stage control and destination
//   wb_*                     WB stage control and destination
//   halted                   sticky, HALT has retired from WB
//   err                      sticky, illegal opcode or stall watchdog expired
// -----------------------------------------------------------------------------
module ctrl_pipe #(
   parameter int unsigned REG_W     = 3,
   parameter logic [4:0]  HALT_OP   = 5'b00000,
   parameter int unsigned STALL_MAX = 255
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [4:0]       id_opcode,
   input  logic [REG_W-1:0] id_rs,
   input  logic [REG_W-1:0] id_rt,
   input  logic             id_rs_used,
   input  logic             id_rt_used,
   input  logic [REG_W-1:0] id_dst,
   input  logic             flush,
   input  logic             mem_stall,
   output logic             id_stall,
   output logic             ex_valid,
   output logic             ex_regwrite,
   output logic             ex_memread,
   output logic             ex_memwrite,
   output logic             ex_alusrc2,
   output logic             ex_branch,
   output logic             ex_jump,
   output logic [REG_W-1:0] ex_dst,
   output logic             mem_valid,
   output logic             mem_regwrite,
   output logic             mem_memread,
   output logic             mem_memwrite,
   output logic             mem_memtoreg,
   output logic [REG_W-1:0] mem_dst,
   output logic             wb_valid,
   output logic             wb_regwrite,
   output logic [REG_W-1:0] wb_dst,
   output logic             halted,
   output logic             err
);

   localparam int unsigned     WD_W     = $clog2(STALL_MAX + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_MAX);

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_HALTED = 2'd2
   } state_t;

   // Control bundle as held in EX. halt tags the HALT instruction so the
   // FSM can see it retire from WB.
   typedef struct packed {
      logic             valid;
      logic             regwrite;
      logic             memread;
      logic             memwrite;
      logic             memtoreg;
      logic             alusrc2;
      logic             branch;
      logic             jump;
      logic             halt;
      logic [REG_W-1:0] dst;
   } ex_ctrl_t;

   typedef struct packed {
      logic             valid;
      logic             regwrite;
      logic             memread;
      logic             memwrite;
      logic             memtoreg;
      logic             halt;
      logic [REG_W-1:0] dst;
   } mem_ctrl_t;

   typedef struct packed {
      logic             valid;
      logic             regwrite;
      logic             halt;
      logic [REG_W-1:0] dst;
   } wb_ctrl_t;

   state_t          state_q, state_d;
   ex_ctrl_t        ex_q, ex_d;
   mem_ctrl_t       mem_q, mem_d;
   wb_ctrl_t        wb_q, wb_d;
   logic            err_q, err_d;
   logic [WD_W-1:0] wd_q, wd_d;

   ex_ctrl_t        dec;
   logic            dec_illegal;
   logic            load_use;
   logic            accept;

   // ------------------------------------------------------------------
   // ID decode
   // ------------------------------------------------------------------
   always_comb begin
      dec         = '0;
      dec_illegal = 1'b0;
      if (id_valid && (id_opcode != HALT_OP) &&
          ((id_opcode == 5'b00010) || (id_opcode == 5'b00011))) begin
         dec_illegal = 1'b1;
      end
      if (id_valid && !dec_illegal) begin
         dec.valid    = 1'b1;
         dec.dst      = id_dst;
         dec.halt     = (id_opcode == HALT_OP);
         dec.memread  = (id_opcode == 5'b10001);
         dec.memwrite = (id_opcode == 5'b10000) || (id_opcode == 5'b10011);
         dec.memtoreg = (id_opcode == 5'b10001);
         dec.branch   = (id_opcode[4:2] == 3'b011);
         // Jump displacement forms (001x0) and register forms (001x1).
         dec.jump     = (id_opcode[4:2] == 3'b001);
         // Second ALU operand comes from the register file for branches,
         // SET ops, BTR and the R-type ALU/shift group; immediate otherwise.
         dec.alusrc2  = !((id_opcode[3:2] == 2'b11) ||
                           (id_opcode[4:1] == 4'b1101) ||
                           ((id_opcode[4:2] == 3'b110) && id_opcode[0]));
         casez (id_opcode)
            5'b010??: dec.regwrite = 1'b1; // immediate ALU
            5'b101??: dec.regwrite = 1'b1; // immediate shifts
            5'b1101?: dec.regwrite = 1'b1; // R-type ALU / shifts
            5'b111??: dec.regwrite = 1'b1; // SET group
            5'b11000: dec.regwrite = 1'b1; // LBI
            5'b11001: dec.regwrite = 1'b1; // BTR
            5'b10010: dec.regwrite = 1'b1; // SLBI
            5'b10001: dec.regwrite = 1'b1; // LD
            5'b10011: dec.regwrite = 1'b1; // STU writes back the address
            5'b0011?: dec.regwrite = 1'b1; // JAL / JALR link
            default:  dec.regwrite = 1'b0;
         endcase
         if (dec.halt) begin
            dec.regwrite = 1'b0;
            dec.memread  = 1'b0;
            dec.memwrite = 1'b0;
            dec.memtoreg = 1'b0;
            dec.branch   = 1'b0;
            dec.jump     = 1'b0;
         end
      end
   end

   // Load in EX whose destination is a source the ID instruction reads.
   assign load_use = ex_q.valid && ex_q.memread &&
                     ((id_rs_used && (id_rs == ex_q.dst)) ||
                      (id_rt_used && (id_rt == ex_q.dst)));

   // ID instruction moves into EX this cycle.
   assign accept = (state_q == ST_RUN) && !mem_stall && !flush && !load_use;

   // ------------------------------------------------------------------
   // Next state: FSM, stage advance, watchdog
   // ------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      ex_d     = ex_q;
      mem_d    = mem_q;
      wb_d     = wb_q;
      err_d    = err_q;
      wd_d     = '0;
      id_stall = mem_stall || (state_q != ST_RUN) || (!flush && load_use);

      // Watchdog counts consecutive frozen cycles and saturates at the limit.
      if (mem_stall) begin
         wd_d = (wd_q == WD_LIMIT) ? wd_q : (wd_q + WD_W'(1));
         if (wd_d == WD_LIMIT) begin
            err_d = 1'b1;
         end
      end

      if (state_q == ST_HALTED) begin
         ex_d  = '0;
         mem_d = '0;
         wb_d  = '0;
      end else if (!mem_stall) begin
         mem_d.valid    = ex_q.valid;
         mem_d.regwrite = ex_q.regwrite;
         mem_d.memread  = ex_q.memread;
         mem_d.memwrite = ex_q.memwrite;
         mem_d.memtoreg = ex_q.memtoreg;
         mem_d.halt     = ex_q.halt;
         mem_d.dst      = ex_q.dst;

         wb_d.valid     = mem_q.valid;
         wb_d.regwrite  = mem_q.regwrite;
         wb_d.halt      = mem_q.halt;
         wb_d.dst       = mem_q.dst;

         // Flush, load-use and drain all put a bubble into EX.
         if (accept) begin
            ex_d = dec;
            if (dec_illegal) begin
               err_d = 1'b1;
            end
            if (dec.halt) begin
               state_d = ST_DRAIN;
            end
         end else begin
            ex_d = '0;
         end

         if ((state_q == ST_DRAIN) && wb_q.halt) begin
            state_d = ST_HALTED;
         end
      end
   end

   // ------------------------------------------------------------------
   // State registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_RUN;
         ex_q    <= '0;
         mem_q   <= '0;
         wb_q    <= '0;
         err_q   <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         ex_q    <= ex_d;
         mem_q   <= mem_d;
         wb_q    <= wb_d;
         err_q   <= err_d;
         wd_q    <= wd_d;
      end
   end

   assign ex_valid     = ex_q.valid;
   assign ex_regwrite  = ex_q.regwrite;
   assign ex_memread   = ex_q.memread;
   assign ex_memwrite  = ex_q.memwrite;
   assign ex_alusrc2   = ex_q.alusrc2;
   assign ex_branch    = ex_q.branch;
   assign ex_jump      = ex_q.jump;
   assign ex_dst       = ex_q.dst;

   assign mem_valid    = mem_q.valid;
   assign mem_regwrite = mem_q.regwrite;
   assign mem_memread  = mem_q.memread;
   assign mem_memwrite = mem_q.memwrite;
   assign mem_memtoreg = mem_q.memtoreg;
   assign mem_dst      = mem_q.dst;

   assign wb_valid     = wb_q.valid;
   assign wb_regwrite  = wb_q.regwrite;
   assign wb_dst       = wb_q.dst;

   assign halted       = (state_q == ST_HALTED);
   assign err          = err_q;

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

   localparam int unsigned REG_W = 3;

   localparam int S_EX    = 0;
   localparam int S_EXDST = 1;
   localparam int S_MEM   = 2;
   localparam int S_WB    = 3;
   localparam int S_STAT  = 4;
   localparam int S_STALL = 5;

   // Opcodes
   localparam logic [4:0] OP_HALT = 5'b00000;
   localparam logic [4:0] OP_LD   = 5'b10001;
   localparam logic [4:0] OP_ST   = 5'b10000;
   localparam logic [4:0] OP_ADD  = 5'b11011;
   localparam logic [4:0] OP_ADDI = 5'b01000;
   localparam logic [4:0] OP_BEQZ = 5'b01100;
   localparam logic [4:0] OP_ILL  = 5'b00010;

   // EX view {0,valid,regwrite,memread,memwrite,alusrc2,branch,jump}
   localparam logic [7:0] EX_LD   = 8'h74;
   localparam logic [7:0] EX_ADD  = 8'h60;
   localparam logic [7:0] EX_BEQZ = 8'h42;
   localparam logic [7:0] EX_ADDI = 8'h64;
   localparam logic [7:0] EX_HALT = 8'h44;
   // MEM view {000,valid,regwrite,memread,memwrite,memtoreg}
   localparam logic [7:0] MEM_LD  = 8'h1D;
   localparam logic [7:0] MEM_ALU = 8'h18;
   localparam logic [7:0] MEM_NW  = 8'h10;
   // WB view {valid,regwrite}
   localparam logic [7:0] WB_RW   = 8'h03;
   localparam logic [7:0] WB_NW   = 8'h02;

   logic             clk;
   logic             rst;
   logic             id_valid;
   logic [4:0]       id_opcode;
   logic [REG_W-1:0] id_rs, id_rt, id_dst;
   logic             id_rs_used, id_rt_used;
   logic             flush, mem_stall;
   logic             id_stall;
   logic             ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_alusrc2, ex_branch, ex_jump;
   logic [REG_W-1:0] ex_dst;
   logic             mem_valid, mem_regwrite, mem_memread, mem_memwrite, mem_memtoreg;
   logic [REG_W-1:0] mem_dst;
   logic             wb_valid, wb_regwrite;
   logic [REG_W-1:0] wb_dst;
   logic             halted, err;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      tag;
      int         sel;
      logic [7:0] exp;
   } exp_t;

   exp_t sbq[$];

   ctrl_pipe #(
      .REG_W     (REG_W),
      .HALT_OP   (5'b00000),
      .STALL_MAX (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .id_valid     (id_valid),
      .id_opcode    (id_opcode),
      .id_rs        (id_rs),
      .id_rt        (id_rt),
      .id_rs_used   (id_rs_used),
      .id_rt_used   (id_rt_used),
      .id_dst       (id_dst),
      .flush        (flush),
      .mem_stall    (mem_stall),
      .id_stall     (id_stall),
      .ex_valid     (ex_valid),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .ex_memwrite  (ex_memwrite),
      .ex_alusrc2   (ex_alusrc2),
      .ex_branch    (ex_branch),
      .ex_jump      (ex_jump),
      .ex_dst       (ex_dst),
      .mem_valid    (mem_valid),
      .mem_regwrite (mem_regwrite),
      .mem_memread  (mem_memread),
      .mem_memwrite (mem_memwrite),
      .mem_memtoreg (mem_memtoreg),
      .mem_dst      (mem_dst),
      .wb_valid     (wb_valid),
      .wb_regwrite  (wb_regwrite),
      .wb_dst       (wb_dst),
      .halted       (halted),
      .err          (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [7:0] observe(input int sel);
      case (sel)
         S_EX:    observe = {1'b0, ex_valid, ex_regwrite, ex_memread, ex_memwrite,
                             ex_alusrc2, ex_branch, ex_jump};
         S_EXDST: observe = {5'b0, ex_dst};
         S_MEM:   observe = {3'b0, mem_valid, mem_regwrite, mem_memread,
                             mem_memwrite, mem_memtoreg};
         S_WB:    observe = {6'b0, wb_valid, wb_regwrite};
         S_STAT:  observe = {6'b0, halted, err};
         S_STALL: observe = {7'b0, id_stall};
         default: observe = 8'hFF;
      endcase
   endfunction

   task automatic push(input string tag, input int sel, input logic [7:0] v);
      exp_t e;
      e.tag = tag;
      e.sel = sel;
      e.exp = v;
      sbq.push_back(e);
   endtask

   task automatic check_out();
      exp_t       e;
      logic [7:0] obs;
      while (sbq.size() > 0) begin
         e   = sbq.pop_front();
         obs = observe(e.sel);
         checks++;
         assert (obs === e.exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.exp);
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_id(input logic v, input logic [4:0] op,
                         input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt,
                         input logic rsu, input logic rtu, input logic [REG_W-1:0] dst);
      id_valid   = v;
      id_opcode  = op;
      id_rs      = rs;
      id_rt      = rt;
      id_rs_used = rsu;
      id_rt_used = rtu;
      id_dst     = dst;
   endtask

   initial begin
      rst       = 1'b0;
      flush     = 1'b0;
      mem_stall = 1'b0;
      set_id(1'b0, 5'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);

      // Power-on reset
      tick();
      tick();
      push("rst_ex",   S_EX,    8'h00);
      push("rst_dst",  S_EXDST, 8'h00);
      push("rst_mem",  S_MEM,   8'h00);
      push("rst_wb",   S_WB,    8'h00);
      push("rst_stat", S_STAT,  8'h00);
      check_out();
      rst = 1'b1;

      // Load-use: LD r1 then ADD reading r1
      set_id(1'b1, OP_LD, 3'd0, 3'd0, 1'b0, 1'b0, 3'd1);
      #1;
      push("ld_nostall", S_STALL, 8'h00);
      check_out();
      tick();
      push("ld_ex",     S_EX,    EX_LD);
      push("ld_exdst",  S_EXDST, 8'h01);
      check_out();

      set_id(1'b1, OP_ADD, 3'd1, 3'd2, 1'b1, 1'b1, 3'd2);
      #1;
      push("lu_stall", S_STALL, 8'h01);
      check_out();
      tick();
      push("lu_bubble", S_EX,  8'h00);
      push("lu_ld_mem", S_MEM, MEM_LD);
      check_out();
      #1;
      push("lu_release", S_STALL, 8'h00);
      check_out();
      tick();
      push("add_ex",    S_EX,    EX_ADD);
      push("add_exdst", S_EXDST, 8'h02);
      push("add_mem",   S_MEM,   8'h00);
      push("ld_wb",     S_WB,    WB_RW);
      check_out();

      // Branch in EX flushes ST in ID
      set_id(1'b1, OP_BEQZ, 3'd3, 3'd0, 1'b1, 1'b0, 3'd0);
      tick();
      push("beqz_ex",  S_EX,  EX_BEQZ);
      push("add_mem2", S_MEM, MEM_ALU);
      push("bub_wb",   S_WB,  8'h00);
      check_out();

      set_id(1'b1, OP_ST, 3'd4, 3'd5, 1'b1, 1'b1, 3'd0);
      flush = 1'b1;
      tick();
      push("flush_ex",   S_EX,  8'h00);
      push("beqz_mem",   S_MEM, MEM_NW);
      push("add_wb",     S_WB,  WB_RW);
      check_out();
      flush = 1'b0;

      set_id(1'b1, OP_ADDI, 3'd2, 3'd0, 1'b1, 1'b0, 3'd3);
      tick();
      push("addi_ex",    S_EX,    EX_ADDI);
      push("addi_exdst", S_EXDST, 8'h03);
      push("bub_mem",    S_MEM,   8'h00);
      push("beqz_wb",    S_WB,    WB_NW);
      check_out();

      // mem_stall with flush held: pipe frozen three cycles
      set_id(1'b1, OP_ST, 3'd4, 3'd5, 1'b1, 1'b1, 3'd0);
      flush     = 1'b1;
      mem_stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1;
         push("frz_stall", S_STALL, 8'h01);
         check_out();
         tick();
         push("frz_ex",    S_EX,    EX_ADDI);
         push("frz_exdst", S_EXDST, 8'h03);
         push("frz_mem",   S_MEM,   8'h00);
         push("frz_wb",    S_WB,    WB_NW);
         push("frz_stat",  S_STAT,  8'h00);
         check_out();
      end
      mem_stall = 1'b0;
      tick();
      push("unfrz_ex",  S_EX,  8'h00);
      push("unfrz_mem", S_MEM, MEM_ALU);
      push("unfrz_wb",  S_WB,  8'h00);
      check_out();
      flush = 1'b0;

      // HALT then ADDI
      set_id(1'b1, OP_HALT, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
      tick();
      push("halt_ex",   S_EX,   EX_HALT);
      push("halt_mem0", S_MEM,  8'h00);
      push("addi_wb",   S_WB,   WB_RW);
      push("halt_st0",  S_STAT, 8'h00);
      check_out();

      set_id(1'b1, OP_ADDI, 3'd0, 3'd0, 1'b1, 1'b0, 3'd4);
      #1;
      push("drain_stall", S_STALL, 8'h01);
      check_out();
      tick();
      push("drain_ex1",  S_EX,   8'h00);
      push("halt_mem",   S_MEM,  MEM_NW);
      push("halt_st1",   S_STAT, 8'h00);
      check_out();
      tick();
      push("drain_ex2",  S_EX,   8'h00);
      push("drain_mem2", S_MEM,  8'h00);
      push("halt_wb",    S_WB,   WB_NW);
      push("halt_st2",   S_STAT, 8'h00);
      check_out();
      tick();
      push("halted_ex",    S_EX,    8'h00);
      push("halted_wb",    S_WB,    8'h00);
      push("halted_st",    S_STAT,  8'h02);
      push("halted_stall", S_STALL, 8'h01);
      check_out();
      tick();
      push("halted_ex2", S_EX,   8'h00);
      push("halted_st2", S_STAT, 8'h02);
      check_out();

      // Reset while halted and mid-stall
      mem_stall = 1'b1;
      rst       = 1'b0;
      tick();
      tick();
      push("rst2_ex",   S_EX,    8'h00);
      push("rst2_dst",  S_EXDST, 8'h00);
      push("rst2_mem",  S_MEM,   8'h00);
      push("rst2_wb",   S_WB,    8'h00);
      push("rst2_stat", S_STAT,  8'h00);
      check_out();
      rst       = 1'b1;
      mem_stall = 1'b0;
      set_id(1'b0, 5'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
      #1;
      push("rst2_run", S_STALL, 8'h00);
      check_out();

      // Flushed HALT leaves the FSM in RUN
      set_id(1'b1, OP_HALT, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
      flush = 1'b1;
      tick();
      push("fhalt_ex", S_EX, 8'h00);
      check_out();
      flush = 1'b0;
      set_id(1'b0, 5'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
      #1;
      push("fhalt_run", S_STALL, 8'h00);
      check_out();
      tick();
      tick();
      tick();
      push("fhalt_st", S_STAT, 8'h00);
      check_out();

      // Illegal opcode becomes a bubble and sets err
      set_id(1'b1, OP_ILL, 3'd0, 3'd0, 1'b0, 1'b0, 3'd6);
      tick();
      push("ill_ex",    S_EX,    8'h00);
      push("ill_exdst", S_EXDST, 8'h00);
      push("ill_stat",  S_STAT,  8'h01);
      check_out();
      set_id(1'b0, 5'b0, 3'd0, 3'd0, 1'b0, 1'b0, 3'd0);
      rst = 1'b0;
      tick();
      rst = 1'b1;
      push("ill_clr", S_STAT, 8'h00);
      check_out();

      // Stall watchdog with limit 4
      mem_stall = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         push("wd_err", S_STAT, (i >= 4) ? 8'h01 : 8'h00);
         check_out();
      end
      mem_stall = 1'b0;
      tick();
      push("wd_sticky", S_STAT, 8'h01);
      check_out();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
